// File: rtl/tff_reg_bank.sv
// Multi-bit T/D flip-flop bank with runtime mode select, change detect and a saturating event counter.
// Optional build macro TFF_BANK_SAT_EN: COUNT mode saturates at all-ones instead of wrapping.
module tff_reg_bank #(
  parameter int unsigned             WIDTH   = 8,
  parameter logic [WIDTH-1:0]        RST_VAL = '0,
  parameter int unsigned             EVT_W   = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic [2:0]       mode_i,
  input  logic [WIDTH-1:0] d_i,
  input  logic [WIDTH-1:0] t_i,
  input  logic             sin_i,
  output logic [WIDTH-1:0] q_o,
  output logic [WIDTH-1:0] qbar_o,
  output logic             changed_o,
  output logic             tc_o,
  output logic [EVT_W-1:0] evt_cnt_o
);

  localparam logic [2:0] MODE_HOLD   = 3'b000;
  localparam logic [2:0] MODE_LOAD   = 3'b001;
  localparam logic [2:0] MODE_TOGGLE = 3'b010;
  localparam logic [2:0] MODE_SETM   = 3'b011;
  localparam logic [2:0] MODE_CLRM   = 3'b100;
  localparam logic [2:0] MODE_SHL    = 3'b101;
  localparam logic [2:0] MODE_SHR    = 3'b110;
  localparam logic [2:0] MODE_COUNT  = 3'b111;

  localparam logic [EVT_W-1:0] EVT_MAX = '1;

  logic [WIDTH-1:0] q_q, q_d;
  logic             changed_q, changed_d;
  logic [EVT_W-1:0] evt_q, evt_d;

  // Next register value by mode; en low forces hold.
  always_comb begin
    q_d = q_q;
    if (en_i) begin
      case (mode_i)
        MODE_HOLD:   q_d = q_q;
        MODE_LOAD:   q_d = d_i;
        MODE_TOGGLE: q_d = q_q ^ t_i;
        MODE_SETM:   q_d = q_q | t_i;
        MODE_CLRM:   q_d = q_q & ~t_i;
        MODE_SHL:    q_d = {q_q[WIDTH-2:0], sin_i};
        MODE_SHR:    q_d = {sin_i, q_q[WIDTH-1:1]};
        MODE_COUNT: begin
`ifdef TFF_BANK_SAT_EN
          q_d = (&q_q) ? q_q : q_q + WIDTH'(1);
`else
          q_d = q_q + WIDTH'(1);
`endif
        end
        default:     q_d = q_q;
      endcase
    end
  end

  // Change detect and saturating event count follow the actual state transition.
  always_comb begin
    changed_d = (q_d != q_q);
    evt_d     = evt_q;
    if (changed_d && (evt_q != EVT_MAX)) begin
      evt_d = evt_q + EVT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_q       <= RST_VAL;
      changed_q <= 1'b0;
      evt_q     <= '0;
    end else begin
      q_q       <= q_d;
      changed_q <= changed_d;
      evt_q     <= evt_d;
    end
  end

  assign q_o       = q_q;
  assign qbar_o    = ~q_q;
  assign changed_o = changed_q;
  assign evt_cnt_o = evt_q;
  assign tc_o      = en_i && (mode_i == MODE_COUNT) && (&q_q);

endmodule

// File: doc/tff_reg_bank.md
Name: tff_reg_bank

Overview:
- Parametrised multi-bit flip-flop bank; generalises the single-bit T/D flip-flop to WIDTH bits.
- Runtime-selectable modes: hold, D-load, per-bit toggle, mask set/clear, shift left/right, count.
- Provides complementary outputs, a change-detect pulse and a saturating change-event counter.
- Building block for control registers, small counters and shift chains elsewhere in the design.

Parameters:
- WIDTH, 8: register width in bits; legal range >= 2.
- RST_VAL, 0: value loaded into q on reset; WIDTH bits.
- EVT_W, 4: width of the change-event counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-low (0 = reset).
- en  in  1  update enable; 0 forces hold in every mode.
- mode  in  3  operation select; encoding given under Behaviour.
- d  in  WIDTH  parallel load data.
- t  in  WIDTH  per-bit toggle / set / clear mask.
- sin  in  1  serial input for the shift modes.
- q  out  WIDTH  register state.
- qbar  out  WIDTH  bitwise complement of q; always equals ~q.
- changed  out  1  registered; 1 for one cycle after an edge where q changed.
- tc  out  1  combinational terminal count; see COUNT mode.
- evt_cnt  out  EVT_W  registered count of edges where q changed; saturates.

Behaviour:
- Reset (rst=0), asynchronous and immediate, including mid-operation:
  - q=RST_VAL, qbar=~RST_VAL, changed=0, evt_cnt=0.
  - The first update happens on the first rising edge after rst returns to 1.
- On a rising edge with en=0: q holds; changed<=0; evt_cnt holds.
- On a rising edge with en=1, next q by mode:
  - 000 HOLD: q
  - 001 LOAD: d
  - 010 TOGGLE: q ^ t
  - 011 SETM: q | t
  - 100 CLRM: q & ~t
  - 101 SHL: {q[WIDTH-2:0], sin}
  - 110 SHR: {sin, q[WIDTH-1:1]}
  - 111 COUNT: q+1, modulo 2^WIDTH (wraps all-ones to 0)
- Latency: one cycle from inputs to q, qbar, changed and evt_cnt.
- changed <= (q_next != q) on every edge. A LOAD of the current value, or TOGGLE with t=0, gives changed=0.
- evt_cnt increments by 1 on each edge where q_next != q. It holds at 2^EVT_W-1 once reached (no wrap).
- tc = en && (mode==111) && (&q). It is high in the cycle before the wrap and is 0 in every other mode.
- Inputs are sampled only at the clock edge; mode changes between edges have no effect on q.
- No illegal encodings exist; all 8 modes are defined.

Optional Feature:
- Macro TFF_BANK_SAT_EN.
- Defined: COUNT mode saturates at all-ones. q stays all-ones, no wrap, and tc stays 1 while mode==111, en=1 and q is all-ones. Holding at all-ones does not assert changed or increment evt_cnt.
- Undefined: COUNT wraps to 0 as specified above.

Test Plan (WIDTH=8, RST_VAL=8'h00, EVT_W=4):
- Assert rst=0 mid-cycle with q=8'h5A -> q=8'h00, qbar=8'hFF, changed=0 and evt_cnt=0 immediately, before the next clock edge.
- LOAD d=8'hA5, then TOGGLE t=8'h0F -> q=8'hA5 then 8'hAA; changed=1 each cycle; evt_cnt=2.
- SETM t=8'h01 on q=8'hAA -> 8'hAB; CLRM t=8'h80 -> 8'h2B; TOGGLE t=8'h00 -> q=8'h2B, changed=0, evt_cnt unchanged.
- SHL with sin=1 for 2 edges on q=8'h81 -> 8'h03, then 8'h07; SHR with sin=0 on 8'h07 -> 8'h03; en=0 with mode=SHL -> q holds at 8'h03.
- LOAD 8'hFE, then COUNT -> 8'hFF with tc=1, then 8'h00 with tc=0. With TFF_BANK_SAT_EN defined: stays 8'hFF, tc=1, changed=0.
- 20 consecutive TOGGLE edges with t=8'hFF -> evt_cnt reaches 4'hF and holds; q alternates each edge.
